// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM encoding, status codes and a
// width helper for the progress counter.
package mwc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPass,
    StFail,
    StTimeout
  } mwc_state_e;

  localparam logic [1:0] STATUS_RUN     = 2'b00;
  localparam logic [1:0] STATUS_PASS    = 2'b01;
  localparam logic [1:0] STATUS_FAIL    = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  // Bits needed to hold 0..depth inclusive.
  function automatic int unsigned prog_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mwc_timer.sv
// RUN-cycle counter with clear/enable; tc flags the last cycle before timeout.
module mwc_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != Last)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tc = (cnt_q == Last);

endmodule

// File: rtl/mem_write_checker.sv
// Passive monitor of the data-memory write port: matches an ordered list of expected
// stores, ignores a scratch window, and holds a sticky verdict. MWC_WRCOUNT_EN adds wr_count.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SEQ_DEPTH      = 2,
  parameter int unsigned SCRATCH_BASE   = 80,
  parameter int unsigned SCRATCH_BYTES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                memwrite,
  input  logic [ADDR_W-1:0]                   dataadr,
  input  logic [DATA_W-1:0]                   writedata,
  input  logic [SEQ_DEPTH*ADDR_W-1:0]         exp_addr_flat,
  input  logic [SEQ_DEPTH*DATA_W-1:0]         exp_data_flat,
  output logic                                done,
  output logic                                pass,
  output logic [1:0]                          status,
  output logic [prog_w(SEQ_DEPTH)-1:0]        progress,
`ifdef MWC_WRCOUNT_EN
  output logic [15:0]                         wr_count,
`endif
  output logic [ADDR_W-1:0]                   fail_addr,
  output logic [DATA_W-1:0]                   fail_data
);

  localparam int unsigned PW  = prog_w(SEQ_DEPTH);
  localparam int unsigned AW1 = ADDR_W + 1;
  // One extra bit keeps the window end from wrapping at the top of the address space.
  localparam logic [AW1-1:0] WinLo = AW1'(SCRATCH_BASE);
  localparam logic [AW1-1:0] WinHi = WinLo + AW1'(SCRATCH_BYTES);

  mwc_state_e        state_q, state_d;
  logic [PW-1:0]     progress_q, progress_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              is_match, in_scratch;
  logic              timer_clear, timer_en, timer_tc;

  mwc_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < int'(SEQ_DEPTH); i++) begin
      if (progress_q == PW'(i)) begin
        cur_addr = exp_addr_flat[i*ADDR_W +: ADDR_W];
        cur_data = exp_data_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  assign is_match   = (dataadr == cur_addr) && (writedata == cur_data);
  assign in_scratch = ({1'b0, dataadr} >= WinLo) && ({1'b0, dataadr} < WinHi);

  always_comb begin
    state_d     = state_q;
    progress_d  = progress_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    unique case (state_q)
      StRun: begin
        timer_en = 1'b1;
        if (memwrite) begin
          if (is_match) begin
            progress_d = progress_q + PW'(1);
            if (progress_d == PW'(SEQ_DEPTH)) state_d = StPass;
          end else if (!in_scratch) begin
            state_d     = StFail;
            fail_addr_d = dataadr;
            fail_data_d = writedata;
          end
        end
        // A deciding store on the last cycle beats the timeout.
        if (state_d == StRun && timer_tc) state_d = StTimeout;
      end
      StIdle, StPass, StFail, StTimeout: begin
        if (start) begin
          state_d     = StRun;
          progress_d  = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          timer_clear = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      progress_q  <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      progress_q  <= progress_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

`ifdef MWC_WRCOUNT_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else if (state_q != StRun && start) begin
      wr_count_q <= '0;
    end else if (state_q == StRun && memwrite && wr_count_q != 16'hFFFF) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

  always_comb begin
    status = STATUS_RUN;
    done   = 1'b0;
    pass   = 1'b0;
    unique case (state_q)
      StPass:    begin status = STATUS_PASS;    done = 1'b1; pass = 1'b1; end
      StFail:    begin status = STATUS_FAIL;    done = 1'b1; end
      StTimeout: begin status = STATUS_TIMEOUT; done = 1'b1; end
      default:   status = STATUS_RUN;
    endcase
  end

  assign progress  = progress_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: default-parameter instance plus a short-timeout
// instance for the TIMEOUT path.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        rst, start, start_to, memwrite;
  logic [31:0] dataadr, writedata;
  logic [63:0] exp_addr_flat, exp_data_flat;

  logic        done, pass;
  logic [1:0]  status, progress;
  logic [31:0] fail_addr, fail_data;
  logic        to_done, to_pass;
  logic [1:0]  to_status, to_progress;
  logic [31:0] to_fail_addr, to_fail_data;
`ifdef MWC_WRCOUNT_EN
  logic [15:0] wr_count, to_wr_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_write_checker dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .exp_addr_flat(exp_addr_flat),
    .exp_data_flat(exp_data_flat),
    .done         (done),
    .pass         (pass),
    .status       (status),
    .progress     (progress),
`ifdef MWC_WRCOUNT_EN
    .wr_count     (wr_count),
`endif
    .fail_addr    (fail_addr),
    .fail_data    (fail_data)
  );

  mem_write_checker #(
    .TIMEOUT_CYCLES(20)
  ) dut_to (
    .clk          (clk),
    .rst          (rst),
    .start        (start_to),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .exp_addr_flat(exp_addr_flat),
    .exp_data_flat(exp_data_flat),
    .done         (to_done),
    .pass         (to_pass),
    .status       (to_status),
    .progress     (to_progress),
`ifdef MWC_WRCOUNT_EN
    .wr_count     (to_wr_count),
`endif
    .fail_addr    (to_fail_addr),
    .fail_data    (to_fail_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each helper drives on a falling edge across exactly one rising edge and returns on
  // the next falling edge, where registered results are already visible.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(negedge clk);
    memwrite = 1'b0; dataadr = '0; writedata = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_verdict(input string tag, input logic [1:0] st, input logic [1:0] pr);
    check({tag, "_status"},   64'(status),   64'(st));
    check({tag, "_progress"}, 64'(progress), 64'(pr));
    check({tag, "_done"},     64'(done),     64'(st != 2'b00));
    check({tag, "_pass"},     64'(pass),     64'(st == 2'b01));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_to = 1'b0; memwrite = 1'b0;
    dataadr = '0; writedata = '0;
    exp_addr_flat = {32'd84, 32'd80};
    exp_data_flat = {32'd7, 32'd1};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_verdict("reset", 2'b00, 2'd0);
    check("reset_fail_addr", 64'(fail_addr), 64'd0);
    check("reset_fail_data", 64'(fail_data), 64'd0);

    // Basic PASS
    pulse_start();
    store(32'd80, 32'd1);
    check_verdict("pass1_mid", 2'b00, 2'd1);
    store(32'd84, 32'd7);
    check_verdict("pass1", 2'b01, 2'd2);

    // Scratch store ignored; start while RUN ignored; sticky PASS
    pulse_start();
    check_verdict("rearm", 2'b00, 2'd0);
    store(32'd80, 32'd1);
    pulse_start();
    check_verdict("start_in_run", 2'b00, 2'd1);
    store(32'd80, 32'd99);
    check_verdict("scratch_ign", 2'b00, 2'd1);
    store(32'd84, 32'd7);
    check_verdict("pass2", 2'b01, 2'd2);
`ifdef MWC_WRCOUNT_EN
    check("wr_count_pass", 64'(wr_count), 64'd3);
    store(32'd100, 32'd5);
    store(32'd84, 32'd7);
    check("wr_count_frozen", 64'(wr_count), 64'd3);
`endif
    store(32'd100, 32'd5);
    check_verdict("pass_sticky", 2'b01, 2'd2);

    // Unexpected address -> FAIL
    pulse_start();
    store(32'd80, 32'd1);
    store(32'd88, 32'd7);
    check_verdict("fail_addr", 2'b10, 2'd1);
    check("fail_addr_lat", 64'(fail_addr), 64'd88);
    check("fail_data_lat", 64'(fail_data), 64'd7);
    store(32'd84, 32'd7);
    check_verdict("fail_sticky", 2'b10, 2'd1);

    // Re-arm clears latches; window edges; right address, wrong data outside window
    pulse_start();
    check("rearm_fail_addr", 64'(fail_addr), 64'd0);
    check("rearm_fail_data", 64'(fail_data), 64'd0);
    store(32'd80, 32'd2);
    store(32'd83, 32'd5);
    check_verdict("win_edge", 2'b00, 2'd0);
    store(32'd80, 32'd1);
    store(32'd84, 32'd8);
    check_verdict("bad_data", 2'b10, 2'd1);
    check("bad_data_addr", 64'(fail_addr), 64'd84);
    check("bad_data_data", 64'(fail_data), 64'd8);

    // Reset mid-run, IDLE stores ignored, then PASS
    pulse_start();
    store(32'd80, 32'd1);
    check_verdict("pre_rst", 2'b00, 2'd1);
    pulse_rst();
    check_verdict("mid_rst", 2'b00, 2'd0);
    check("mid_rst_fail_addr", 64'(fail_addr), 64'd0);
    store(32'd84, 32'd7);
    check_verdict("idle_store", 2'b00, 2'd0);
    pulse_start();
    store(32'd80, 32'd1);
    store(32'd84, 32'd7);
    check_verdict("pass3", 2'b01, 2'd2);

    // TIMEOUT: verdict exactly 20 cycles after the start edge
    @(negedge clk);
    start_to = 1'b1;
    @(negedge clk);
    start_to = 1'b0;
    repeat (19) @(negedge clk);
    check("to_before", 64'(to_status), 64'd0);
    check("to_done_before", 64'(to_done), 64'd0);
    @(negedge clk);
    check("to_status", 64'(to_status), 64'd3);
    check("to_done", 64'(to_done), 64'd1);
    check("to_pass", 64'(to_pass), 64'd0);
    repeat (3) @(negedge clk);
    check("to_sticky", 64'(to_status), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
